// File: rtl/seq_multiplier_pkg.sv
// Shared types and defaults for the sequential shift-add multiplier.
// State encoding and the default operand width live here.
package seq_multiplier_pkg;

    localparam int DEF_SIZE = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_multiplier_rc_adder.sv
// Combinational W-bit ripple-carry adder, carry-in fixed at 0.
// The carry-out is exported so the product stays exact.
module rc_adder #(
    parameter int W = 32
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] s,
    output logic         co
);

    logic [W:0] cy;

    assign cy[0] = 1'b0;

    // one full-adder cell per bit, carry rippling upward
    for (genvar i = 0; i < W; i++) begin : g_bit
        assign s[i]    = x[i] ^ y[i] ^ cy[i];
        assign cy[i+1] = (x[i] & y[i]) | (cy[i] & (x[i] ^ y[i]));
    end

    assign co = cy[W];

endmodule

// File: rtl/seq_multiplier.sv
// Unsigned shift-add multiplier: one partial-product step per clock.
// FSM, counter, multiplicand and product registers live here.
module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter int SIZE = DEF_SIZE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SIZE-1:0]   a,
    input  logic [SIZE-1:0]   b,
    output logic              busy,
    output logic              done,
    output logic [2*SIZE-1:0] p
);

    localparam int CW = $clog2(SIZE + 1);

    state_t          state;
    logic [SIZE-1:0] mcand;
    logic [CW-1:0]   cnt;
    logic [SIZE-1:0] sum;
    logic            cout;
    logic [SIZE-1:0] hi;
    logic            c;

    rc_adder #(
        .W (SIZE)
    ) u_add (
        .x  (p[2*SIZE-1:SIZE]),
        .y  (mcand),
        .s  (sum),
        .co (cout)
    );

    // add the multiplicand into the upper half only when the current LSB is set
    always_comb begin
        c  = 1'b0;
        hi = p[2*SIZE-1:SIZE];
        if (p[0]) begin
            c  = cout;
            hi = sum;
        end
    end

    // control FSM with registered busy/done and the product shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            p     <= '0;
            mcand <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        mcand <= a;
                        p     <= {{SIZE{1'b0}}, b};
                        cnt   <= CW'(SIZE);
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    p   <= {c, hi, p[SIZE-1:1]};
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: SIZE=32 and SIZE=8 instances side by side,
// checked every cycle against a latency/product model.
module tb_seq_multiplier;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        st0 = 1'b0;
    logic [31:0] a0 = '0;
    logic [31:0] b0 = '0;
    logic        busy0;
    logic        done0;
    logic [63:0] p0;

    logic        st1 = 1'b0;
    logic [7:0]  a1 = '0;
    logic [7:0]  b1 = '0;
    logic        busy1;
    logic        done1;
    logic [15:0] p1;

    always #5 clk = ~clk;

    seq_multiplier #(.SIZE(32)) dut32 (
        .clk   (clk),
        .rst   (rst),
        .start (st0),
        .a     (a0),
        .b     (b0),
        .busy  (busy0),
        .done  (done0),
        .p     (p0)
    );

    seq_multiplier #(.SIZE(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (st1),
        .a     (a1),
        .b     (b1),
        .busy  (busy1),
        .done  (done1),
        .p     (p1)
    );

    // common-width views of both instances
    logic         stv[2];
    logic [63:0]  av[2];
    logic [63:0]  bv[2];
    logic         busyv[2];
    logic         donev[2];
    logic [127:0] pv[2];
    int           sz[2];

    assign stv[0]   = st0;
    assign stv[1]   = st1;
    assign av[0]    = {32'b0, a0};
    assign av[1]    = {56'b0, a1};
    assign bv[0]    = {32'b0, b0};
    assign bv[1]    = {56'b0, b1};
    assign busyv[0] = busy0;
    assign busyv[1] = busy1;
    assign donev[0] = done0;
    assign donev[1] = done1;
    assign pv[0]    = {64'b0, p0};
    assign pv[1]    = {112'b0, p1};
    assign sz[0]    = 32;
    assign sz[1]    = 8;

    // model: cycles left until done, product of the accepted operands
    int           rem[2]    = '{0, 0};
    logic [127:0] mprod[2]  = '{'0, '0};
    logic         edone[2]  = '{1'b0, 1'b0};
    logic         pvalid[2] = '{1'b0, 1'b0};
    logic [127:0] ep[2]     = '{'0, '0};

    always @(posedge clk) begin
        for (int j = 0; j < 2; j++) begin
            if (rst) begin
                rem[j]    = 0;
                edone[j]  = 1'b0;
                ep[j]     = '0;
                pvalid[j] = 1'b1;
            end else if (rem[j] > 0) begin
                rem[j] = rem[j] - 1;
                if (rem[j] == 0) begin
                    edone[j]  = 1'b1;
                    ep[j]     = mprod[j];
                    pvalid[j] = 1'b1;
                end
            end else begin
                edone[j] = 1'b0;
                if (stv[j]) begin
                    rem[j]    = sz[j];
                    mprod[j]  = {64'b0, av[j]} * {64'b0, bv[j]};
                    pvalid[j] = 1'b0;
                end
            end
        end
    end

    // hand-computed products expected at successive done pulses of dut32
    logic [63:0] lit_exp[8];
    int          lit_req = 0;
    int          lit_ack = 0;
    logic        fin = 1'b0;

    int total = 0;
    int bad   = 0;

    // single compare process, sampling on the falling edge
    always @(negedge clk) begin
        for (int j = 0; j < 2; j++) begin
            total++;
            if (busyv[j] !== (rem[j] > 0)) begin
                bad++;
                $display("FAIL busy[%0d] got=%0b want=%0b t=%0t",
                         j, busyv[j], (rem[j] > 0), $time);
            end
            total++;
            if (donev[j] !== edone[j]) begin
                bad++;
                $display("FAIL done[%0d] got=%0b want=%0b t=%0t",
                         j, donev[j], edone[j], $time);
            end
            if (pvalid[j]) begin
                total++;
                if (pv[j] !== ep[j]) begin
                    bad++;
                    $display("FAIL p[%0d] got=%h want=%h t=%0t",
                             j, pv[j], ep[j], $time);
                end
            end
        end
        if (donev[0] === 1'b1 && lit_ack < lit_req) begin
            total++;
            if (p0 !== lit_exp[lit_ack]) begin
                bad++;
                $display("FAIL lit%0d got=%h want=%h",
                         lit_ack, p0, lit_exp[lit_ack]);
            end
            lit_ack++;
        end
        if (fin) begin
            total++;
            if (lit_ack != lit_req) begin
                bad++;
                $display("FAIL lit_seen got=%0d want=%0d", lit_ack, lit_req);
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic push_lit(input logic [63:0] v);
        lit_exp[lit_req] = v;
        lit_req++;
    endtask

    initial begin
        cyc(3);
        rst = 1'b0;
        cyc(2);

        // 3*5
        push_lit(64'h0000_0000_0000_000F);
        a0 = 32'd3; b0 = 32'd5; st0 = 1'b1;
        cyc(1);
        st0 = 1'b0;
        cyc(40);

        // all-ones, exercises the carry-out
        push_lit(64'hFFFF_FFFE_0000_0001);
        a0 = 32'hFFFF_FFFF; b0 = 32'hFFFF_FFFF; st0 = 1'b1;
        cyc(1);
        st0 = 1'b0;
        cyc(40);

        // back-to-back, start held through RUN and DONE
        push_lit(64'h0);
        push_lit(64'h0000_0000_1234_5678);
        a0 = 32'h0; b0 = 32'hDEAD_BEEF; st0 = 1'b1;
        cyc(1);
        a0 = 32'h1234_5678; b0 = 32'h1;
        cyc(32);
        cyc(1);
        st0 = 1'b0;
        cyc(40);

        // start during RUN is ignored
        push_lit(64'd42);
        a0 = 32'd7; b0 = 32'd6; st0 = 1'b1;
        cyc(1);
        st0 = 1'b0;
        cyc(9);
        a0 = 32'd1; b0 = 32'd1; st0 = 1'b1;
        cyc(1);
        st0 = 1'b0;
        cyc(40);

        // reset mid-run aborts with no done
        a0 = 32'd9; b0 = 32'd9; st0 = 1'b1;
        a1 = 8'd9;  b1 = 8'd9;  st1 = 1'b1;
        cyc(1);
        st0 = 1'b0; st1 = 1'b0;
        cyc(4);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(40);

        // reset and start on the same edge
        rst = 1'b1; st0 = 1'b1; st1 = 1'b1;
        cyc(1);
        rst = 1'b0; st0 = 1'b0; st1 = 1'b0;
        cyc(4);

        // random pairs on both widths, back-to-back on dut32
        for (int i = 0; i < 1000; i++) begin
            if (i == 0) begin
                a0 = '1; b0 = '1; a1 = '1; b1 = '1;
            end else if (i == 1) begin
                a0 = '1; b0 = '0; a1 = '0; b1 = '1;
            end else begin
                a0 = $urandom;
                b0 = $urandom;
                a1 = 8'($urandom);
                b1 = 8'($urandom);
            end
            st0 = 1'b1; st1 = 1'b1;
            cyc(1);
            st0 = 1'b0; st1 = 1'b0;
            cyc(32);
        end
        cyc(40);

        fin = 1'b1;
        cyc(5);
        $display("FAIL summary not reached");
        $fatal(1);
    end

endmodule
